// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register carrying data and control bundles under valid/ready,
// with flush and an optional two-entry skid buffer that keeps in_ready registered.
module pipe_stage_reg #(
    parameter int unsigned DATA_W  = 96,
    parameter int unsigned CTRL_W  = 8,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    localparam int unsigned OCC_W = 2;

    logic              main_valid, main_valid_n;
    logic [DATA_W-1:0] main_data,  main_data_n;
    logic [CTRL_W-1:0] main_ctrl,  main_ctrl_n;
    logic              skid_valid, skid_valid_n;
    logic [DATA_W-1:0] skid_data,  skid_data_n;
    logic [CTRL_W-1:0] skid_ctrl,  skid_ctrl_n;
    logic              ready_q,    ready_n;
    logic [OCC_W-1:0]  occ_q,      occ_n;
    logic              in_fire;
    logic              out_fire;

    // Skid mode exposes a registered ready; single-register mode passes out_ready through.
    assign in_ready  = SKID_EN ? ready_q : (rstn & (~main_valid | out_ready));
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_valid & out_ready;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign occupancy = occ_q;

    // Next-state: every entry that empties also has its ctrl zeroed on the same edge.
    always_comb begin
        main_valid_n = main_valid;
        main_data_n  = main_data;
        main_ctrl_n  = main_ctrl;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        skid_ctrl_n  = skid_ctrl;

        if (flush) begin
            main_valid_n = 1'b0;
            main_ctrl_n  = '0;
            skid_valid_n = 1'b0;
            skid_ctrl_n  = '0;
        end else if (SKID_EN) begin
            if (skid_valid) begin
                if (out_fire) begin
                    main_valid_n = 1'b1;
                    main_data_n  = skid_data;
                    main_ctrl_n  = skid_ctrl;
                    skid_valid_n = 1'b0;
                    skid_ctrl_n  = '0;
                end
            end else if (in_fire) begin
                if (~main_valid | out_fire) begin
                    main_valid_n = 1'b1;
                    main_data_n  = in_data;
                    main_ctrl_n  = in_ctrl;
                end else begin
                    skid_valid_n = 1'b1;
                    skid_data_n  = in_data;
                    skid_ctrl_n  = in_ctrl;
                end
            end else if (out_fire) begin
                main_valid_n = 1'b0;
                main_ctrl_n  = '0;
            end
        end else begin
            if (in_fire) begin
                main_valid_n = 1'b1;
                main_data_n  = in_data;
                main_ctrl_n  = in_ctrl;
            end else if (out_fire) begin
                main_valid_n = 1'b0;
                main_ctrl_n  = '0;
            end
        end

        if (!SKID_EN) begin
            skid_valid_n = 1'b0;
            skid_data_n  = '0;
            skid_ctrl_n  = '0;
        end

        ready_n = ~skid_valid_n;
        occ_n   = OCC_W'(main_valid_n) + OCC_W'(skid_valid_n);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
            ready_q    <= 1'b0;
            occ_q      <= '0;
        end else begin
            main_valid <= main_valid_n;
            main_data  <= main_data_n;
            main_ctrl  <= main_ctrl_n;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
            skid_ctrl  <= skid_ctrl_n;
            ready_q    <= ready_n;
            occ_q      <= occ_n;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid and non-skid instances share stimulus and are each
// checked every cycle against a queue-based model, plus directed literal checks.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [95:0] d;
        logic [7:0]  c;
    } ent_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [95:0] in_data;
    logic [7:0]  in_ctrl;
    logic        flush;
    logic        out_ready;

    logic        ir1, ov1, ir0, ov0;
    logic [95:0] od1, od0;
    logic [7:0]  oc1, oc0;
    logic [1:0]  occ1, occ0;

    int checks   = 0;
    int failures = 0;

    ent_t q1[$];
    ent_t q0[$];
    bit   rdy1   = 1'b0;
    bit   mvalid = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(8), .SKID_EN(1'b1)) u_skid (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir1),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .out_ctrl(oc1), .occupancy(occ1)
    );

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(8), .SKID_EN(1'b0)) u_noskid (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir0),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .out_ctrl(oc0), .occupancy(occ0)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_inst(input string nm, input int sz, input ent_t hd, input bit exp_rdy,
                            input logic ov, input logic [95:0] od, input logic [7:0] oc,
                            input logic [1:0] occ, input logic ir);
        chk({nm, ".occ"}, 128'(occ), 128'(sz));
        chk({nm, ".out_valid"}, 128'(ov), 128'(sz > 0));
        if (sz > 0) begin
            chk({nm, ".out_data"}, 128'(od), 128'(hd.d));
            chk({nm, ".out_ctrl"}, 128'(oc), 128'(hd.c));
        end else begin
            chk({nm, ".bubble_ctrl"}, 128'(oc), 128'(0));
        end
        chk({nm, ".in_ready"}, 128'(ir), 128'(exp_rdy));
    endtask

    // Reference model: a FIFO of held bundles; pop on downstream fire, push on upstream fire.
    always @(posedge clk) begin
        bit   r1, r0;
        ent_t e;
        r1 = rdy1;
        r0 = rstn && (q0.size() == 0 || out_ready);
        e.d = in_data;
        e.c = in_ctrl;
        if (!rstn || flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (q1.size() > 0 && out_ready) void'(q1.pop_front());
            if (in_valid && r1) q1.push_back(e);
            if (q0.size() > 0 && out_ready) void'(q0.pop_front());
            if (in_valid && r0) q0.push_back(e);
        end
        rdy1   = rstn && (q1.size() < 2);
        mvalid = 1'b1;
    end

    always @(negedge clk) begin
        ent_t h1, h0;
        if (mvalid) begin
            h1 = (q1.size() > 0) ? q1[0] : '0;
            h0 = (q0.size() > 0) ? q0[0] : '0;
            chk_inst("skid", q1.size(), h1, rdy1, ov1, od1, oc1, occ1, ir1);
            chk_inst("noskid", q0.size(), h0,
                     rstn && (q0.size() == 0 || out_ready), ov0, od0, oc0, occ0, ir0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    localparam logic [95:0] A = 96'hA;
    localparam logic [95:0] B = 96'hB;
    localparam logic [95:0] C = 96'hC;
    localparam logic [95:0] D = 96'hD;

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'hFF;
        in_data   = 96'h1234;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset with a bundle offered.
        tick;
        tick;
        @(negedge clk);
        chk("rst.out_valid", 128'(ov1), 128'(0));
        chk("rst.out_ctrl", 128'(oc1), 128'(0));
        chk("rst.occ", 128'(occ1), 128'(0));
        chk("rst.in_ready", 128'(ir1), 128'(0));
        chk("rst.in_ready_noskid", 128'(ir0), 128'(0));
        tick;
        rstn     = 1'b1;
        in_valid = 1'b0;
        tick;
        @(negedge clk);
        chk("rel.in_ready", 128'(ir1), 128'(1));

        // Streaming.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 96'(i);
            in_ctrl  = 8'(i);
            @(negedge clk);
            chk("str.in_ready", 128'(ir1), 128'(1));
            if (i > 0) begin
                chk("str.out_data", 128'(od1), 128'(i - 1));
                chk("str.out_valid", 128'(ov1), 128'(1));
                chk("str.occ", 128'(occ1), 128'(1));
            end
            tick;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("str.last", 128'(od1), 128'(15));
        tick;
        @(negedge clk);
        chk("str.drained", 128'(ov1), 128'(0));

        // Back-pressure.
        in_valid = 1'b1; in_data = A; in_ctrl = 8'h11; out_ready = 1'b1;
        tick;
        out_ready = 1'b0; in_data = B; in_ctrl = 8'h22;
        @(negedge clk);
        chk("bp.accept_b", 128'(ir1), 128'(1));
        tick;
        in_data = C; in_ctrl = 8'h33;
        @(negedge clk);
        chk("bp.occ_full", 128'(occ1), 128'(2));
        chk("bp.ready_low", 128'(ir1), 128'(0));
        chk("bp.head_a", 128'(od1), 128'(A));
        tick;
        @(negedge clk);
        chk("bp.hold_occ", 128'(occ1), 128'(2));
        chk("bp.hold_ready", 128'(ir1), 128'(0));
        tick;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.emit_a", 128'(od1), 128'(A));
        chk("bp.emit_a_ready", 128'(ir1), 128'(0));
        tick;
        @(negedge clk);
        chk("bp.emit_b", 128'(od1), 128'(B));
        chk("bp.ready_back", 128'(ir1), 128'(1));
        tick;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp.emit_c", 128'(od1), 128'(C));
        chk("bp.emit_c_valid", 128'(ov1), 128'(1));
        tick;

        // Flush when full.
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h3C; in_data = 96'h51;
        tick;
        in_data = 96'h52;
        tick;
        @(negedge clk);
        chk("fl.occ_full", 128'(occ1), 128'(2));
        chk("fl.ctrl", 128'(oc1), 128'(8'h3C));
        flush = 1'b1; in_data = D;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("fl.out_valid", 128'(ov1), 128'(0));
        chk("fl.out_ctrl", 128'(oc1), 128'(0));
        chk("fl.occ", 128'(occ1), 128'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            @(negedge clk);
            chk("fl.no_d", 128'(ov1), 128'(0));
        end

        // Flush with a downstream fire and an upstream fire in the same cycle.
        in_valid = 1'b1; in_data = 96'hE; in_ctrl = 8'h44;
        tick;
        flush = 1'b1; in_data = 96'hF;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flf.out_valid", 128'(ov1), 128'(0));
        chk("flf.occ", 128'(occ1), 128'(0));
        chk("flf.in_ready", 128'(ir1), 128'(1));
        tick;

        // Bubbles between bundles with all control bits set.
        in_ctrl = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 96'(100 + i);
            @(negedge clk);
            chk("bub.idle_valid", 128'(ov1), 128'(0));
            chk("bub.idle_ctrl", 128'(oc1), 128'(0));
            tick;
            in_valid = 1'b0;
            @(negedge clk);
            chk("bub.valid", 128'(ov1), 128'(1));
            chk("bub.ctrl", 128'(oc1), 128'(8'hFF));
            tick;
        end

        // Randomised traffic with rare flushes and one mid-run reset.
        for (int n = 0; n < 1000; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = (n < 500) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            rstn      = (n != 500);
            in_data   = {$urandom, $urandom, $urandom};
            in_ctrl   = 8'($urandom);
            tick;
        end
        rstn = 1'b1; in_valid = 1'b0; flush = 1'b0;
        tick;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, parametrised pipeline stage register for the RV32 core. It replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block that carries a data bundle and a control bundle under valid/ready flow control. It adds stall, flush and an optional two-entry skid buffer, so back-pressure does not form a combinational ready path through the pipeline. Control bits are forced to zero in any bubble, so an invalid slot can never cause a memory or register write.

## Interface
- DATA_W, 96: width of the data bundle (pc, pc+4, rd, ALU result, store data, ...); must be ≥1.
- CTRL_W, 8: width of the control bundle (mem_read, mem_write, reg_write, wb_src, ...); must be ≥1.
- SKID_EN, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream has a valid bundle.
- in_ready  out  1  stage can accept a bundle this cycle.
- in_data  in  DATA_W  upstream data bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- flush  in  1  synchronous squash of all held entries.
- out_valid  out  1  out_data/out_ctrl hold a valid bundle.
- out_ready  in  1  downstream accepts the bundle this cycle.
- out_data  out  DATA_W  data of the head entry.
- out_ctrl  out  CTRL_W  control of the head entry; all-zero whenever out_valid=0.
- occupancy  out  2  number of held entries (0..2; ≤1 when SKID_EN=0).

## Operation
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - A bundle is transferred only on a fire.
- State:
  - Head entry: main_valid, main_data, main_ctrl.
  - Skid entry: skid_valid, skid_data, skid_ctrl. This entry exists only when SKID_EN=1.
  - out_* is driven directly from the head entry.
- Priority per cycle: rstn=0 > flush=1 > normal update.
- Reset:
  - All valid bits, data, ctrl, and occupancy are cleared to 0.
  - in_ready=0 while rstn=0.
  - in_valid is ignored while rstn=0.
- Flush:
  - main_valid and skid_valid are cleared to 0; both ctrl registers are cleared to 0.
  - Data registers keep their values.
  - A bundle presented in the flush cycle is discarded, even if in_fire=1. Upstream is flushed by the same hazard unit.
- SKID_EN=1, normal update:
  - in_ready = ~skid_valid. It is a registered value with no dependence on out_ready.
  - skid_valid & out_fire: head <= skid, skid <= empty. in_fire is impossible in this cycle.
  - ~skid_valid & in_fire & (~main_valid | out_fire): head <= in.
  - ~skid_valid & in_fire & main_valid & ~out_fire: skid <= in; the stage becomes full.
  - ~in_fire & out_fire & ~skid_valid: head <= empty.
  - Otherwise: hold (this is the stall).
- SKID_EN=0, normal update:
  - in_ready = ~main_valid | out_ready (combinational).
  - in_fire: head <= in.
  - Else if out_fire: head <= empty.
- Bubble rule: whenever an entry becomes empty, its ctrl register is written 0 in the same edge.
- Ordering is strict FIFO; no bundle is ever duplicated or dropped, except on flush.
- occupancy = main_valid + skid_valid, registered.

## Timing
- Latency: a bundle accepted on edge N appears on out_* after edge N (one cycle) if the stage was empty or draining.
- Throughput: one bundle per cycle when out_ready is held at 1, in both modes.
- SKID_EN=1 full condition:
  - in_ready falls the cycle after the skid entry fills.
  - It rises the cycle after the first out_fire.
  - One bubble-free refill follows: skid moves to head on the same edge.
- out_ready=0 with occupancy=2: state holds indefinitely and in_ready stays 0.
- Flush and out_fire in the same cycle: the downstream fire completes, since the current outputs are consumed. All entries are then empty after the edge.
- Reset mid-operation: all state is cleared on the first clk edge with rstn=0. out_valid is 0 from that edge onward.
- No combinational path from out_ready to in_ready when SKID_EN=1.

## Test plan
- Reset: hold rstn=0 for 2 cycles with in_valid=1 and in_ctrl=8'hFF. Required:
  - out_valid=0, out_ctrl=0, occupancy=0 and in_ready=0.
  - After release, in_ready=1.
- Streaming: SKID_EN=1, out_ready=1, send 16 bundles with data=i and ctrl=i[7:0]. Required:
  - Each bundle appears one cycle after acceptance, in order, with no gaps.
  - occupancy stays ≤1.
- Back-pressure: accept A, then drop out_ready for 3 cycles while offering B and C. Required:
  - B is accepted into the skid entry and occupancy=2.
  - in_ready=0 and C is held upstream.
  - Raise out_ready: the stage emits A, B, C on consecutive cycles.
- Flush when full: occupancy=2 with ctrl=8'h3C, assert flush with in_valid=1 and data=D. Required:
  - Next cycle: out_valid=0, out_ctrl=0, occupancy=0.
  - D never appears at the output.
- SKID_EN=0 mode: apply random in_valid/out_ready over 1000 cycles against a scoreboard. Required:
  - Order is preserved and occupancy ≤1.
  - in_ready equals ~main_valid|out_ready every cycle.
- Bubble control: insert an idle cycle between bundles with ctrl=8'hFF. Required: out_ctrl=0 in every cycle where out_valid=0.
